// File: rtl/rf_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write counters gating decode issue.
// Optional SB_WB_BYPASS_EN lets a source read the write-back value in the write-back cycle.
module rf_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned AW       = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rs1,
  input  logic [AW-1:0]       issue_rs2,
  input  logic                issue_rd_we,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_waddr,
  input  logic                flush,
  output logic                sb_err,
  output logic [AW+CNT_W-1:0] inflight
`ifdef SB_WB_BYPASS_EN
  ,
  output logic                rs1_byp,
  output logic                rs2_byp
`endif
);

  localparam int unsigned IW = AW + CNT_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             sb_err_q, sb_err_d;
  logic [IW-1:0]    inflight_q, inflight_d;

  logic rs1_raw, rs2_raw, rd_sat, fire, inc_en, dec_en;

  assign rs1_raw = (issue_rs1 != '0) && (cnt_q[issue_rs1] != '0);
  assign rs2_raw = (issue_rs2 != '0) && (cnt_q[issue_rs2] != '0);
  assign rd_sat  = issue_rd_we && (issue_rd != '0) && (cnt_q[issue_rd] == CntMax);

`ifdef SB_WB_BYPASS_EN
  logic rs1_hit, rs2_hit;

  // Last outstanding write to rsN retires this cycle; decode takes wb data instead.
  assign rs1_hit = wb_valid && (wb_waddr == issue_rs1) && (cnt_q[issue_rs1] == CNT_W'(1)) &&
                   !(issue_rd_we && (issue_rd == issue_rs1));
  assign rs2_hit = wb_valid && (wb_waddr == issue_rs2) && (cnt_q[issue_rs2] == CNT_W'(1)) &&
                   !(issue_rd_we && (issue_rd == issue_rs2));
  assign rs1_byp  = rs1_raw && rs1_hit;
  assign rs2_byp  = rs2_raw && rs2_hit;
  assign rs1_busy = rs1_raw && !rs1_hit;
  assign rs2_busy = rs2_raw && !rs2_hit;
`else
  assign rs1_busy = rs1_raw;
  assign rs2_busy = rs2_raw;
`endif

  assign issue_ready = !rs1_busy && !rs2_busy && !rd_sat && !flush;
  assign fire        = issue_valid && issue_ready;
  assign inc_en      = fire && issue_rd_we && (issue_rd != '0);
  assign dec_en      = wb_valid && (wb_waddr != '0);

  always_comb begin
    logic inc_r;
    logic dec_r;
    cnt_d      = cnt_q;
    sb_err_d   = sb_err_q;
    inflight_d = inflight_q;
    inc_r      = 1'b0;
    dec_r      = 1'b0;
    cnt_d[0]   = '0;
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_d[r] = '0;
      end
      inflight_d = '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        inc_r = inc_en && (issue_rd == AW'(r));
        dec_r = dec_en && (wb_waddr == AW'(r));
        if (inc_r && !dec_r) begin
          cnt_d[r]   = cnt_q[r] + CNT_W'(1);
          inflight_d = inflight_d + IW'(1);
        end else if (dec_r && !inc_r) begin
          if (cnt_q[r] != '0) begin
            cnt_d[r]   = cnt_q[r] - CNT_W'(1);
            inflight_d = inflight_d - IW'(1);
          end else begin
            sb_err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q   <= 1'b0;
      inflight_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sb_err_q   <= sb_err_d;
      inflight_q <= inflight_d;
    end
  end

  assign sb_err   = sb_err_q;
  assign inflight = inflight_q;

endmodule
